dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, memory size in 32-bit words (power of two, >= 4).
REQ-002 Parameter LATENCY, default 3, cycles from request acceptance to completion (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_p_addr  input  32  byte address from core; word index = i_p_addr[log2(DEPTH)+1:2]; other bits ignored.
REQ-006 i_p_read  input  1  read request, held by core until waitrequest low.
REQ-007 i_p_write  input  1  write request, held by core until waitrequest low.
REQ-008 i_p_byteenable  input  4  per-byte write enable; bit n selects writedata[8n+7:8n].
REQ-009 i_p_writedata  input  32  write data.
REQ-010 o_p_readdata  output  32  read data, registered, valid in completion cycle, held until next read completes.
REQ-011 o_p_waitrequest  output  1  stall to core; high while a transfer is pending; core pipeline registers advance only when low.

Function
REQ-012 FSM states: IDLE, BUSY, DONE.
REQ-013 IDLE: request = i_p_read | i_p_write; o_p_waitrequest = request (combinational), so core stalls in the request cycle T.
REQ-014 IDLE with request at cycle T: capture word index, byteenable, writedata, op; load counter = 1; next state BUSY if LATENCY > 1, else DONE.
REQ-015 BUSY: o_p_waitrequest = 1; counter increments each cycle; when counter == LATENCY-1, next state DONE.
REQ-016 DONE occurs at cycle T+LATENCY; o_p_waitrequest = 0 in DONE.
REQ-017 Read: o_p_readdata loads the addressed word on the edge entering DONE; the value is stable through DONE and afterwards.
REQ-018 Write: the captured enabled bytes are written on the edge leaving DONE; disabled bytes are unchanged; o_p_readdata is unchanged.
REQ-019 DONE always transitions to IDLE; back-to-back transfers therefore take LATENCY+1 cycles each.
REQ-020 Read and write both high: treated as write; read ignored.
REQ-021 Request deasserted or altered during BUSY/DONE: ignored; the captured transfer completes unchanged.
REQ-022 Write with byteenable 4'b0000: completes with normal timing; memory is unchanged.
REQ-023 Address beyond DEPTH words wraps modulo DEPTH (upper bits dropped).
REQ-024 Read of a word written by the immediately preceding transfer returns the new data.

Reset
REQ-025 rst high at an edge: state = IDLE, counter = 0, o_p_readdata = 32'h00000000, captured registers cleared.
REQ-026 While rst is high, o_p_waitrequest = 0 regardless of request inputs.
REQ-027 Reset mid-transfer aborts it; a pending write is not performed; memory contents are not cleared by reset.

Structure
REQ-028 A shared package holds the FSM state encoding, the default LATENCY and DEPTH, and the byte-enable width constant.
REQ-029 Storage is a sub-module dmem_ram: single port, synchronous read, synchronous byte-masked write, no reset.
REQ-030 The FSM, counter and capture registers are in dmem_responder; no other sub-modules.

Verification
REQ-031 LATENCY=3, read addr 0x10 preloaded 0xDEADBEEF at T: waitrequest high at T, T+1, T+2 and low at T+3; readdata = 0xDEADBEEF at T+3.
REQ-032 Write 0x11223344 with byteenable 4'b0101 to addr 0x20 (old value 0xAABBCCDD), then read 0x20 -> 0xAA22CC44; each transfer takes 4 cycles.
REQ-033 LATENCY=1, read request held continuously -> waitrequest toggles 1,0,1,0; a new read completes every 2 cycles.
REQ-034 rst high at T+1 during a write to addr 0x30 -> state IDLE, waitrequest 0, readdata 0; a later read of 0x30 returns the pre-write value.
REQ-035 DEPTH=256, write 0x5A5A5A5A to addr 0x400 -> a read of addr 0x000 returns 0x5A5A5A5A (wrap).
REQ-036 Read and write both high to addr 0x8 with data 0x1 and byteenable 4'hF -> treated as write; readdata unchanged; a later read of 0x8 returns 0x1.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and sizing constants.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 3;
    localparam int BE_W        = 4;
    // Wide enough for the largest legal LATENCY (15).
    localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word memory: synchronous read, synchronous byte-masked write, no reset.
module dmem_ram
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic [AW-1:0]   addr,
    input  logic            rd_en,
    input  logic            wr_en,
    input  logic [BE_W-1:0] be,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-masked write and enabled registered read share the one address port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: stalls the core for LATENCY cycles per transfer.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     i_p_addr,
    input  logic            i_p_read,
    input  logic            i_p_write,
    input  logic [BE_W-1:0] i_p_byteenable,
    input  logic [31:0]     i_p_writedata,
    output logic [31:0]     o_p_readdata,
    output logic            o_p_waitrequest
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(LATENCY - 1);
    localparam state_t           FIRST_ST = (LATENCY > 1) ? ST_BUSY : ST_DONE;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [AW-1:0]     cap_idx;
    logic [BE_W-1:0]   cap_be;
    logic [31:0]       cap_wdata;
    logic              cap_write;
    logic              rd_valid;

    logic              req;
    logic [AW-1:0]     req_idx;
    logic [AW-1:0]     ram_addr;
    logic              ram_rd_en;
    logic              ram_wr_en;
    logic [31:0]       ram_rdata;
    logic              unused_addr_bits;

    assign req              = i_p_read | i_p_write;
    assign req_idx          = i_p_addr[AW+1:2];
    assign unused_addr_bits = ^{i_p_addr[31:AW+2], i_p_addr[1:0]};

    // In IDLE the RAM sees the live request address so a LATENCY=1 read can
    // complete on the very next edge; afterwards it uses the captured index.
    assign ram_addr  = (state == ST_IDLE) ? req_idx : cap_idx;
    assign ram_wr_en = !rst && (state == ST_DONE) && cap_write;

    // The RAM read fires on exactly the edge that enters DONE for a read.
    always_comb begin
        ram_rd_en = 1'b0;
        if (!rst) begin
            if (state == ST_IDLE) begin
                ram_rd_en = req && !i_p_write && (LATENCY == 1);
            end else if (state == ST_BUSY) begin
                ram_rd_en = (cnt == LAT_M1) && !cap_write;
            end
        end
    end

    // Stall while a request is being accepted or is in flight; never during reset.
    always_comb begin
        o_p_waitrequest = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: o_p_waitrequest = req;
                ST_BUSY: o_p_waitrequest = 1'b1;
                default: o_p_waitrequest = 1'b0;
            endcase
        end
    end

    // The RAM output register only holds a read result once a read has completed
    // since reset; before that the core sees zero.
    assign o_p_readdata = rd_valid ? ram_rdata : 32'h0000_0000;

    // Transfer FSM: capture in IDLE, count through BUSY, single DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_idx   <= '0;
            cap_be    <= '0;
            cap_wdata <= '0;
            cap_write <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            if (ram_rd_en) begin
                rd_valid <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        cap_idx   <= req_idx;
                        cap_be    <= i_p_byteenable;
                        cap_wdata <= i_p_writedata;
                        cap_write <= i_p_write;
                        cnt       <= CNT_W'(1);
                        state     <= FIRST_ST;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAT_M1) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .rd_en (ram_rd_en),
        .wr_en (ram_wr_en),
        .be    (cap_be),
        .wdata (cap_wdata),
        .rdata (ram_rdata)
    );

endmodule
